// File: rtl/cod_linha_numero.sv
// Row-scanning line-number encoder: strobes rows, senses a shared column and
// reports the debounced lowest active row as the 3-bit code {A,B,C}.
module cod_linha_numero #(
    parameter int ROWS      = 7,
    parameter int SCAN_DIV  = 4,
    parameter int DEB_COUNT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            col_n,
    output logic [ROWS-1:0] row_n,
    output logic            A,
    output logic            B,
    output logic            C,
    output logic            valid,
    output logic            novo
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [3:0]    DEB    = 4'(DEB_COUNT);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        state_q, state_d;
    logic          col_meta_q, col_sync_q;
    logic          scan_on_q, scan_on_d;
    logic [DW-1:0] d_q, d_d;
    logic [RW-1:0] r_q, r_d;
    logic          hit_q, hit_d;
    logic [2:0]    h_q, h_d;
    logic [2:0]    cand_q, cand_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    rel_q, rel_d;
    logic [2:0]    code_q, code_d;
    logic          novo_q, novo_d;

    logic       sense, sample, frame_end, f_hit, valid_now;
    logic [2:0] r_code, f_h;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        scan_on_d = scan_on_q;
        d_d       = d_q;
        r_d       = r_q;
        hit_d     = hit_q;
        h_d       = h_q;
        cand_d    = cand_q;
        press_d   = press_q;
        rel_d     = rel_q;
        code_d    = code_q;
        novo_d    = 1'b0;

        sense     = ~col_sync_q;
        r_code    = 3'(r_q);
        sample    = scan_on_q && (d_q == D_LAST);
        frame_end = sample && (r_q == R_LAST);
        // The row sampled on the frame-end edge still counts toward this frame.
        f_hit     = hit_q | sense;
        f_h       = hit_q ? h_q : r_code;
        valid_now = (state_q == HELD) || (state_q == RELEASE_WAIT);

        if (!en) begin
            scan_on_d = 1'b0;
            d_d       = '0;
            r_d       = '0;
            hit_d     = 1'b0;
            h_d       = '0;
            press_d   = '0;
            rel_d     = '0;
            if (state_q == PRESS_WAIT)   state_d = IDLE;
            if (state_q == RELEASE_WAIT) state_d = HELD;
        end else begin
            scan_on_d = 1'b1;
            if (scan_on_q) begin
                if (d_q == D_LAST) begin
                    d_d = '0;
                    r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
                end else begin
                    d_d = d_q + DW'(1);
                end
            end

            if (sample && sense && !hit_q) begin
                hit_d = 1'b1;
                h_d   = r_code;
            end

            if (frame_end) begin
                hit_d = 1'b0;
                h_d   = '0;
                if (f_hit) begin
                    if (f_h == cand_q) begin
                        press_d = (press_q == DEB) ? press_q : press_q + 4'd1;
                    end else begin
                        cand_d  = f_h;
                        press_d = 4'd1;
                    end
                    rel_d = '0;
                end else begin
                    press_d = '0;
                    rel_d   = (rel_q == DEB) ? rel_q : rel_q + 4'd1;
                end

                case (state_q)
                    IDLE:         if (f_hit)  state_d = PRESS_WAIT;
                    PRESS_WAIT:   if (!f_hit) state_d = IDLE;
                    HELD:         if (!f_hit) state_d = RELEASE_WAIT;
                    RELEASE_WAIT: if (f_hit)  state_d = HELD;
                    default:      state_d = IDLE;
                endcase

                if ((press_d == DEB) && (!valid_now || (cand_d != code_q))) begin
                    code_d  = cand_d;
                    novo_d  = 1'b1;
                    state_d = HELD;
                end
                if (rel_d == DEB) state_d = IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_meta_q <= 1'b1;
            col_sync_q <= 1'b1;
            scan_on_q  <= 1'b0;
            d_q        <= '0;
            r_q        <= '0;
            hit_q      <= 1'b0;
            h_q        <= '0;
            cand_q     <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            code_q     <= '0;
            novo_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
            scan_on_q  <= scan_on_d;
            d_q        <= d_d;
            r_q        <= r_d;
            hit_q      <= hit_d;
            h_q        <= h_d;
            cand_q     <= cand_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            code_q     <= code_d;
            novo_q     <= novo_d;
        end
    end

    always_comb begin
        row_n = '1;
        for (int i = 0; i < ROWS; i++) begin
            row_n[i] = !(scan_on_q && (r_q == RW'(i)));
        end
    end

    assign {A, B, C} = code_q;
    assign valid     = (state_q == HELD) || (state_q == RELEASE_WAIT);
    assign novo      = novo_q;

endmodule

// File: tb/tb_cod_linha_numero.sv
// Directed bench for cod_linha_numero: a key-matrix model drives col_n from
// row_n, expected codes are queued at press time and popped on each novo.
module tb_cod_linha_numero;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       col_n;
    logic [6:0] row_n;
    logic       A, B, C, valid, novo;

    logic [6:0] mask;
    logic [2:0] sb[$];
    logic       novo_prev = 1'b0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // Pressed keys pull the column low whenever their row is strobed.
    assign col_n = ~|(~row_n & mask);

    cod_linha_numero #(.ROWS(7), .SCAN_DIV(4), .DEB_COUNT(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .col_n (col_n),
        .row_n (row_n),
        .A     (A),
        .B     (B),
        .C     (C),
        .valid (valid),
        .novo  (novo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_hold(input int n, input logic v, input string tag);
        int errs = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid !== v) errs++;
        end
        check(tag, errs, 0);
    endtask

    // Called at a frame start with the key pattern already applied.
    task automatic press_confirm(input logic [2:0] code, input logic valid_before);
        run_hold(83, valid_before, "valid_hold_pre");
        check("novo_early", novo, 1'b0);
        cycles(1);
        check("novo_on_time", novo, 1'b1);
        check("code", {A, B, C}, code);
        check("valid_after", valid, 1'b1);
    endtask

    always @(negedge clk) begin
        if (novo === 1'b1) begin
            check("novo_width", novo_prev, 1'b0);
            if (sb.size() == 0) begin
                check("novo_unexpected", novo, 1'b0);
            end else begin
                check("novo_code", {A, B, C}, sb.pop_front());
            end
        end
        novo_prev = novo;
    end

    initial begin
        logic [6:0] e;
        rst  = 1'b1;
        en   = 1'b1;
        mask = '0;
        cycles(2);
        check("rst_row_n", row_n, 7'h7f);
        check("rst_code", {A, B, C}, 3'b000);
        check("rst_valid", valid, 1'b0);
        check("rst_novo", novo, 1'b0);
        rst = 1'b0;
        cycles(1);

        // Idle scan: two frames of row strobes, 4 cycles per row.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 28; k++) begin
                e = ~(7'd1 << (k / 4));
                check("row_n_scan", row_n, e);
                check("idle_valid", valid, 1'b0);
                cycles(1);
            end
        end

        mask = 7'd1 << 5;
        sb.push_back(3'b101);
        press_confirm(3'b101, 1'b0);
        run_hold(56, 1'b1, "valid_while_held");

        mask = '0;
        run_hold(83, 1'b1, "valid_during_release");
        cycles(1);
        check("released_valid", valid, 1'b0);
        check("released_code", {A, B, C}, 3'b101);

        mask = (7'd1 << 2) | (7'd1 << 5);
        sb.push_back(3'b010);
        press_confirm(3'b010, 1'b0);
        mask = 7'd1 << 5;
        sb.push_back(3'b101);
        press_confirm(3'b101, 1'b1);
        mask = '0;
        run_hold(83, 1'b1, "valid_release2");
        cycles(1);
        check("released2_valid", valid, 1'b0);

        for (int f = 0; f < 10; f++) begin
            mask = (f % 2 == 0) ? (7'd1 << 3) : 7'd0;
            run_hold(28, 1'b0, "bounce_valid");
        end
        mask = '0;
        check("sb_empty_bounce", sb.size(), 0);

        mask = 7'd1 << 4;
        sb.push_back(3'b100);
        press_confirm(3'b100, 1'b0);
        cycles(10);
        rst = 1'b1;
        #1;
        check("midrst_row_n", row_n, 7'h7f);
        check("midrst_code", {A, B, C}, 3'b000);
        check("midrst_valid", valid, 1'b0);
        check("midrst_novo", novo, 1'b0);
        cycles(3);
        rst = 1'b0;
        cycles(1);
        sb.push_back(3'b100);
        press_confirm(3'b100, 1'b0);
        mask = '0;
        cycles(2);
        check("sb_empty_end", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
